// File: rtl/cells_frame_commit_if.sv
// Bus between the frame commit stage and its neighbours: the engine
// handshake, the frame tick, the next-generation RAM ports and the VRAM
// write port. The commit stage uses the slave view; the driving side
// (engine, memories, display timing) uses the master view.
interface cells_frame_commit_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 2
);
  logic                  start_i;
  logic                  frame_tick_i;
  logic [DATA_WIDTH-1:0] ram_rd_data_i;
  logic [ADDR_WIDTH-1:0] ram_rd_address_o;
  logic [ADDR_WIDTH-1:0] ram_wr_address_o;
  logic [DATA_WIDTH-1:0] ram_wr_data_o;
  logic                  ram_wr_en_o;
  logic [ADDR_WIDTH-1:0] vram_wr_address_o;
  logic [DATA_WIDTH-1:0] vram_wr_data_o;
  logic                  vram_wr_en_o;
  logic                  ready_o;
  logic                  busy_o;

  modport master (
    output start_i,
    output frame_tick_i,
    output ram_rd_data_i,
    input  ram_rd_address_o,
    input  ram_wr_address_o,
    input  ram_wr_data_o,
    input  ram_wr_en_o,
    input  vram_wr_address_o,
    input  vram_wr_data_o,
    input  vram_wr_en_o,
    input  ready_o,
    input  busy_o
  );

  modport slave (
    input  start_i,
    input  frame_tick_i,
    input  ram_rd_data_i,
    output ram_rd_address_o,
    output ram_wr_address_o,
    output ram_wr_data_o,
    output ram_wr_en_o,
    output vram_wr_address_o,
    output vram_wr_data_o,
    output vram_wr_en_o,
    output ready_o,
    output busy_o
  );
endinterface

// File: rtl/cells_frame_commit.sv
// Frame commit stage of the cell engine. After reset both memories are
// cleared. On each done pulse from the next-state engine the next-generation
// RAM is streamed into VRAM one cell per cycle (1-cycle read latency) while
// the RAM cell just read is zeroed behind the read pointer. Once a frame
// tick has been seen (during or after the pass) ready pulses once so the
// engine can compute the next generation.
module cells_frame_commit #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  cells_frame_commit_if.slave bus
);

  localparam int                    CELL_COUNT = ACTIVE_COLUMNS * ACTIVE_ROWS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(CELL_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    CLEAR     = 3'd0,
    IDLE      = 3'd1,
    COPY      = 3'd2,
    DRAIN     = 3'd3,
    WAIT_TICK = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  tick_pending;

  logic [ADDR_WIDTH-1:0] rd_address;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [DATA_WIDTH-1:0] vram_data;
  logic                  wr_en;
  logic                  ready;
  logic                  busy;

  // Sequencer: walks the cell counter through clear / copy and tracks ticks.
  // The counter stops at LAST_ADDR and is explicitly reloaded, never wrapped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= CLEAR;
      addr         <= '0;
      tick_pending <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (bus.frame_tick_i) tick_pending <= 1'b1;
          if (addr == LAST_ADDR) begin
            addr  <= '0;
            state <= WAIT_TICK;
          end else begin
            addr <= addr + ADDR_ONE;
          end
        end
        IDLE: begin
          // Ticks here are dropped: no pass is running, so nothing to pace.
          // The start cycle already issues read 0; COPY continues from 1.
          if (bus.start_i) begin
            if (addr == LAST_ADDR) begin
              state <= DRAIN;
            end else begin
              addr  <= addr + ADDR_ONE;
              state <= COPY;
            end
          end
        end
        COPY: begin
          if (bus.frame_tick_i) tick_pending <= 1'b1;
          if (addr == LAST_ADDR) state <= DRAIN;
          else                   addr  <= addr + ADDR_ONE;
        end
        DRAIN: begin
          if (bus.frame_tick_i) tick_pending <= 1'b1;
          addr  <= '0;
          state <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (bus.frame_tick_i || tick_pending) begin
            tick_pending <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          addr         <= '0;
          tick_pending <= 1'b0;
          state        <= CLEAR;
        end
      endcase
    end
  end

  // Memory strobes and status decoded from state and counter. Writes in COPY
  // trail the read address by one so a cell is never read and written in the
  // same cycle; everything is forced low while reset is held.
  always_comb begin
    rd_address = '0;
    wr_address = '0;
    vram_data  = '0;
    wr_en      = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state)
      CLEAR: begin
        wr_address = addr;
        wr_en      = 1'b1;
        busy       = 1'b1;
      end
      IDLE: begin
        rd_address = addr;
        // The accepted start cycle issues read 0 and counts as part of the pass.
        busy       = bus.start_i;
      end
      COPY: begin
        rd_address = addr;
        wr_address = addr - ADDR_ONE;
        vram_data  = bus.ram_rd_data_i;
        wr_en      = 1'b1;
        busy       = 1'b1;
      end
      DRAIN: begin
        wr_address = addr;
        vram_data  = bus.ram_rd_data_i;
        wr_en      = 1'b1;
        busy       = 1'b1;
      end
      WAIT_TICK: begin
        ready = bus.frame_tick_i | tick_pending;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
    if (reset_i) begin
      rd_address = '0;
      wr_address = '0;
      vram_data  = '0;
      wr_en      = 1'b0;
      ready      = 1'b0;
      busy       = 1'b0;
    end
  end

  // Both memories share the write address and strobe; RAM is always zeroed.
  always_comb begin
    bus.ram_rd_address_o  = rd_address;
    bus.ram_wr_address_o  = wr_address;
    bus.ram_wr_data_o     = '0;
    bus.ram_wr_en_o       = wr_en;
    bus.vram_wr_address_o = wr_address;
    bus.vram_wr_data_o    = vram_data;
    bus.vram_wr_en_o      = wr_en;
    bus.ready_o           = ready;
    bus.busy_o            = busy;
  end

endmodule

// File: tb/tb_cells_frame_commit.sv
// Bench for cells_frame_commit with a 4x3 cell grid (12 cells). Behavioural
// RAM/VRAM models sit on the bus; expected writes are queued as stimulus is
// driven and popped as the design emits write strobes.
module tb_cells_frame_commit;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int N    = COLS * ROWS;
  localparam int AW   = 4;
  localparam int DW   = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cells_frame_commit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cells_frame_commit #(
    .ACTIVE_COLUMNS(COLS),
    .ACTIVE_ROWS   (ROWS),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  logic [DW-1:0] ram      [N];
  logic [DW-1:0] vram     [N];
  logic [DW-1:0] ram_init [N];
  logic [DW-1:0] vram_init[N];
  logic          load_mem = 1'b0;

  int  checks = 0;
  int  errors = 0;
  wr_t vq[$];
  wr_t rq[$];

  // Memory models: synchronous write, registered read with 1-cycle latency.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < N; i++) begin
        ram[i]  <= ram_init[i];
        vram[i] <= vram_init[i];
      end
    end else begin
      if (bus.ram_wr_en_o === 1'b1)  ram[bus.ram_wr_address_o]   <= bus.ram_wr_data_o;
      if (bus.vram_wr_en_o === 1'b1) vram[bus.vram_wr_address_o] <= bus.vram_wr_data_o;
    end
    bus.ram_rd_data_i <= ram[bus.ram_rd_address_o];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  // One cycle: change inputs on the falling edge, settle, then sample.
  task automatic step(input logic r, input logic s, input logic t);
    @(negedge clk);
    rst              = r;
    bus.start_i      = s;
    bus.frame_tick_i = t;
    #1;
  endtask

  task automatic test_reset();
    wr_t exp;
    for (int i = 0; i < N; i++) begin
      ram_init[i]  = 2'b11;
      vram_init[i] = 2'b11;
    end
    load_mem = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, k == 0);
      checks++;
      if ({bus.ram_rd_address_o, bus.ram_wr_address_o, bus.ram_wr_data_o, bus.ram_wr_en_o,
           bus.vram_wr_address_o, bus.vram_wr_data_o, bus.vram_wr_en_o, bus.ready_o,
           bus.busy_o} !== 20'd0) begin
        errors++;
        $display("FAIL reset_outputs k=%0d got wr_en=%b vwr_en=%b ready=%b busy=%b want all 0",
                 k, bus.ram_wr_en_o, bus.vram_wr_en_o, bus.ready_o, bus.busy_o);
      end
    end
    load_mem = 1'b0;
    for (int a = 0; a < N; a++) begin
      vq.push_back('{addr: AW'(a), data: '0});
      rq.push_back('{addr: AW'(a), data: '0});
    end
    for (int c = 0; c < 26; c++) begin
      step(1'b0, 1'b0, c == 20);
      checks++;
      if (bus.busy_o !== (c < N)) begin
        errors++;
        $display("FAIL clear_busy c=%0d got %b want %b", c, bus.busy_o, c < N);
      end
      checks++;
      if (bus.ready_o !== (c == 20)) begin
        errors++;
        $display("FAIL clear_ready c=%0d got %b want %b", c, bus.ready_o, c == 20);
      end
      if (bus.vram_wr_en_o === 1'b1) begin
        checks++;
        if (vq.size() == 0) begin
          errors++;
          $display("FAIL clear_vram_extra c=%0d got addr %0d want no write", c, bus.vram_wr_address_o);
        end else begin
          exp = vq.pop_front();
          if ({bus.vram_wr_address_o, bus.vram_wr_data_o} !== exp) begin
            errors++;
            $display("FAIL clear_vram c=%0d got %0d/%0d want %0d/%0d", c,
                     bus.vram_wr_address_o, bus.vram_wr_data_o, exp.addr, exp.data);
          end
        end
      end
      if (bus.ram_wr_en_o === 1'b1) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL clear_ram_extra c=%0d got addr %0d want no write", c, bus.ram_wr_address_o);
        end else begin
          exp = rq.pop_front();
          if ({bus.ram_wr_address_o, bus.ram_wr_data_o} !== exp) begin
            errors++;
            $display("FAIL clear_ram c=%0d got %0d/%0d want %0d/%0d", c,
                     bus.ram_wr_address_o, bus.ram_wr_data_o, exp.addr, exp.data);
          end
        end
      end
    end
    checks++;
    if (vq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL clear_missing got %0d/%0d writes left want 0/0", vq.size(), rq.size());
    end
    vq.delete();
    rq.delete();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ram[i] !== 2'b00 || vram[i] !== 2'b00) begin
        errors++;
        $display("FAIL clear_mem cell %0d got ram=%0d vram=%0d want 0/0", i, ram[i], vram[i]);
      end
    end
  endtask

  // Tick in IDLE dropped; copy of a%4; start in WAIT_TICK ignored; ready on later tick.
  task automatic test_copy();
    wr_t exp;
    int  busy_cnt = 0;
    for (int i = 0; i < N; i++) begin
      ram_init[i]  = DW'(i % 4);
      vram_init[i] = 2'b11;
    end
    load_mem = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    load_mem = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.ready_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_tick_ready got %b want 0", bus.ready_o);
    end
    for (int a = 0; a < N; a++) begin
      vq.push_back('{addr: AW'(a), data: DW'(a % 4)});
      rq.push_back('{addr: AW'(a), data: '0});
    end
    for (int c = 0; c < 28; c++) begin
      step(1'b0, c == 0 || c == 18, c == 24);
      if (bus.busy_o === 1'b1) busy_cnt++;
      checks++;
      if (bus.busy_o !== (c <= 12)) begin
        errors++;
        $display("FAIL copy_busy c=%0d got %b want %b", c, bus.busy_o, c <= 12);
      end
      checks++;
      if (bus.ready_o !== (c == 24)) begin
        errors++;
        $display("FAIL copy_ready c=%0d got %b want %b", c, bus.ready_o, c == 24);
      end
      if (bus.busy_o === 1'b1 && bus.ram_wr_en_o === 1'b1) begin
        checks++;
        if (bus.ram_rd_address_o == bus.ram_wr_address_o && c < 12) begin
          errors++;
          $display("FAIL copy_rw_collide c=%0d got rd=wr=%0d want different", c, bus.ram_rd_address_o);
        end
      end
      if (bus.vram_wr_en_o === 1'b1) begin
        checks++;
        if (vq.size() == 0) begin
          errors++;
          $display("FAIL copy_vram_extra c=%0d got addr %0d want no write", c, bus.vram_wr_address_o);
        end else begin
          exp = vq.pop_front();
          if ({bus.vram_wr_address_o, bus.vram_wr_data_o} !== exp) begin
            errors++;
            $display("FAIL copy_vram c=%0d got %0d/%0d want %0d/%0d", c,
                     bus.vram_wr_address_o, bus.vram_wr_data_o, exp.addr, exp.data);
          end
        end
      end
      if (bus.ram_wr_en_o === 1'b1) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL copy_ram_extra c=%0d got addr %0d want no write", c, bus.ram_wr_address_o);
        end else begin
          exp = rq.pop_front();
          if ({bus.ram_wr_address_o, bus.ram_wr_data_o} !== exp) begin
            errors++;
            $display("FAIL copy_ram c=%0d got %0d/%0d want %0d/%0d", c,
                     bus.ram_wr_address_o, bus.ram_wr_data_o, exp.addr, exp.data);
          end
        end
      end
    end
    checks++;
    if (busy_cnt != 13) begin
      errors++;
      $display("FAIL copy_busy_count got %0d want 13", busy_cnt);
    end
    checks++;
    if (vq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL copy_missing got %0d/%0d writes left want 0/0", vq.size(), rq.size());
    end
    vq.delete();
    rq.delete();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ram[i] !== 2'b00 || vram[i] !== DW'(i % 4)) begin
        errors++;
        $display("FAIL copy_mem cell %0d got ram=%0d vram=%0d want 0/%0d", i, ram[i], vram[i], i % 4);
      end
    end
  endtask

  // Two ticks mid-copy collapse to one ready; start during COPY ignored.
  task automatic test_tick_collapse();
    wr_t exp;
    for (int i = 0; i < N; i++) begin
      ram_init[i]  = DW'((i + 1) % 4);
      vram_init[i] = 2'b00;
    end
    load_mem = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    load_mem = 1'b0;
    for (int a = 0; a < N; a++) vq.push_back('{addr: AW'(a), data: DW'((a + 1) % 4)});
    for (int c = 0; c < 22; c++) begin
      step(1'b0, c == 0 || c == 5, c == 3 || c == 7);
      checks++;
      if (bus.busy_o !== (c <= 12)) begin
        errors++;
        $display("FAIL collapse_busy c=%0d got %b want %b", c, bus.busy_o, c <= 12);
      end
      checks++;
      if (bus.ready_o !== (c == 13)) begin
        errors++;
        $display("FAIL collapse_ready c=%0d got %b want %b", c, bus.ready_o, c == 13);
      end
      if (bus.vram_wr_en_o === 1'b1) begin
        checks++;
        if (vq.size() == 0) begin
          errors++;
          $display("FAIL collapse_vram_extra c=%0d got addr %0d want no write", c, bus.vram_wr_address_o);
        end else begin
          exp = vq.pop_front();
          if ({bus.vram_wr_address_o, bus.vram_wr_data_o} !== exp) begin
            errors++;
            $display("FAIL collapse_vram c=%0d got %0d/%0d want %0d/%0d", c,
                     bus.vram_wr_address_o, bus.vram_wr_data_o, exp.addr, exp.data);
          end
        end
      end
    end
    checks++;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL collapse_missing got %0d writes left want 0", vq.size());
    end
    vq.delete();
  endtask

  // Tick on the DRAIN cycle gives ready next cycle; second pass starts at once
  // and copies the zeroed RAM.
  task automatic test_back_to_back();
    wr_t exp;
    for (int i = 0; i < N; i++) begin
      ram_init[i]  = DW'((i * 3) % 4);
      vram_init[i] = 2'b01;
    end
    load_mem = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    load_mem = 1'b0;
    for (int a = 0; a < N; a++) vq.push_back('{addr: AW'(a), data: DW'((a * 3) % 4)});
    for (int a = 0; a < N; a++) vq.push_back('{addr: AW'(a), data: '0});
    for (int c = 0; c < 33; c++) begin
      step(1'b0, c == 0 || c == 14, c == 12 || c == 30);
      checks++;
      if (bus.busy_o !== (c <= 12 || (c >= 14 && c <= 26))) begin
        errors++;
        $display("FAIL b2b_busy c=%0d got %b want %b", c, bus.busy_o, c <= 12 || (c >= 14 && c <= 26));
      end
      checks++;
      if (bus.ready_o !== (c == 13 || c == 30)) begin
        errors++;
        $display("FAIL b2b_ready c=%0d got %b want %b", c, bus.ready_o, c == 13 || c == 30);
      end
      if (bus.vram_wr_en_o === 1'b1) begin
        checks++;
        if (vq.size() == 0) begin
          errors++;
          $display("FAIL b2b_vram_extra c=%0d got addr %0d want no write", c, bus.vram_wr_address_o);
        end else begin
          exp = vq.pop_front();
          if ({bus.vram_wr_address_o, bus.vram_wr_data_o} !== exp) begin
            errors++;
            $display("FAIL b2b_vram c=%0d got %0d/%0d want %0d/%0d", c,
                     bus.vram_wr_address_o, bus.vram_wr_data_o, exp.addr, exp.data);
          end
        end
      end
    end
    checks++;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing got %0d writes left want 0", vq.size());
    end
    vq.delete();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (vram[i] !== 2'b00) begin
        errors++;
        $display("FAIL b2b_vram_final cell %0d got %0d want 0", i, vram[i]);
      end
    end
  endtask

  // Reset at copy cycle 5 abandons the copy; CLEAR restarts at 0; the tick seen
  // before reset is forgotten, so ready waits for the next tick.
  task automatic test_reset_mid_copy();
    wr_t exp;
    logic exp_busy;
    for (int i = 0; i < N; i++) begin
      ram_init[i]  = DW'(i % 4);
      vram_init[i] = 2'b11;
    end
    load_mem = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    load_mem = 1'b0;
    for (int a = 0; a < 4; a++) vq.push_back('{addr: AW'(a), data: DW'(a % 4)});
    for (int a = 0; a < N; a++) vq.push_back('{addr: AW'(a), data: '0});
    for (int c = 0; c < 27; c++) begin
      step(c == 5, c == 0, c == 2 || c == 24);
      exp_busy = (c <= 4) || (c >= 6 && c <= 17);
      if (c == 5) begin
        checks++;
        if ({bus.ram_wr_en_o, bus.vram_wr_en_o, bus.ready_o, bus.busy_o,
             bus.ram_rd_address_o, bus.vram_wr_address_o} !== 12'd0) begin
          errors++;
          $display("FAIL midreset_outputs got wr_en=%b vwr_en=%b ready=%b busy=%b want all 0",
                   bus.ram_wr_en_o, bus.vram_wr_en_o, bus.ready_o, bus.busy_o);
        end
      end
      checks++;
      if (bus.busy_o !== exp_busy) begin
        errors++;
        $display("FAIL midreset_busy c=%0d got %b want %b", c, bus.busy_o, exp_busy);
      end
      checks++;
      if (bus.ready_o !== (c == 24)) begin
        errors++;
        $display("FAIL midreset_ready c=%0d got %b want %b", c, bus.ready_o, c == 24);
      end
      if (bus.vram_wr_en_o === 1'b1) begin
        checks++;
        if (vq.size() == 0) begin
          errors++;
          $display("FAIL midreset_vram_extra c=%0d got addr %0d want no write", c, bus.vram_wr_address_o);
        end else begin
          exp = vq.pop_front();
          if ({bus.vram_wr_address_o, bus.vram_wr_data_o} !== exp) begin
            errors++;
            $display("FAIL midreset_vram c=%0d got %0d/%0d want %0d/%0d", c,
                     bus.vram_wr_address_o, bus.vram_wr_data_o, exp.addr, exp.data);
          end
        end
      end
    end
    checks++;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL midreset_missing got %0d writes left want 0", vq.size());
    end
    vq.delete();
  endtask

  initial begin
    bus.start_i      = 1'b0;
    bus.frame_tick_i = 1'b0;
    test_reset();
    test_copy();
    test_tick_collapse();
    test_back_to_back();
    test_reset_mid_copy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
